// File: rtl/mastermind_core.sv
// -----------------------------------------------------------------------------
// mastermind_core
//
// Purpose
//   Scoring engine for a Mastermind game. The first press of the enter button
//   loads the secret code word. Each press after that scores the presented
//   guess against the secret, giving exact and partial counts. The game stops
//   on a full match (win) or when the round budget runs out (lose).
//
// Optional feature
//   MASTERMIND_PARTIAL_EN : when defined, partial counts (right symbol, wrong
//                           slot) are computed. When undefined, partial is
//                           tied to 0 and no symbol-count logic is built.
//
// Parameters
//   NUM_SLOTS  : symbol positions per code word
//   SYM_W      : bits per symbol
//   MAX_ROUNDS : guesses allowed per game
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   enter_L     in   active-low enter button, already synchronised
//   new_game_L  in   active-low new-game request, synchronous level
//   hMove       in   code word, slot 0 in the lowest SYM_W bits
//   loading     out  high while waiting for the secret word
//   exact       out  slots with the right symbol in the right position
//   partial     out  right symbols in the wrong position
//   round       out  guesses scored this game (saturates at MAX_ROUNDS)
//   hMove_last  out  last scored guess
//   win / lose  out  game outcome flags
//
// State table
//   LOAD  | waiting for the secret word
//   GUESS | scoring guesses
//   WON   | secret matched; presses ignored
//   LOST  | round budget used up; presses ignored
// -----------------------------------------------------------------------------
module mastermind_core #(
    parameter int NUM_SLOTS  = 4,
    parameter int SYM_W      = 4,
    parameter int MAX_ROUNDS = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enter_L,
    input  logic                              new_game_L,
    input  logic [NUM_SLOTS*SYM_W-1:0]        hMove,
    output logic                              loading,
    output logic [$clog2(NUM_SLOTS+1)-1:0]    exact,
    output logic [$clog2(NUM_SLOTS+1)-1:0]    partial,
    output logic [$clog2(MAX_ROUNDS+1)-1:0]   round,
    output logic [NUM_SLOTS*SYM_W-1:0]        hMove_last,
    output logic                              win,
    output logic                              lose
);

    localparam int WORD_W = NUM_SLOTS * SYM_W;
    localparam int EW     = $clog2(NUM_SLOTS + 1);
    localparam int RW     = $clog2(MAX_ROUNDS + 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_GUESS = 2'd1,
        S_WON   = 2'd2,
        S_LOST  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_enter_q;
    logic [WORD_W-1:0]   r_secret;
    logic [WORD_W-1:0]   r_last;
    logic [EW-1:0]       r_exact;
    logic [EW-1:0]       r_partial;
    logic [RW-1:0]       r_round;

    logic                w_press;
    logic [EW-1:0]       w_exact;
    logic [EW-1:0]       w_partial;
    logic [RW-1:0]       w_round_inc;
    logic                w_full_match;

    // Falling edge of enter_L: high on the previous edge, low now.
    assign w_press = r_enter_q & ~enter_L;

    // Exact matches between the presented word and the stored secret.
    always_comb begin
        w_exact = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hMove[i*SYM_W +: SYM_W] == r_secret[i*SYM_W +: SYM_W]) begin
                w_exact = w_exact + EW'(1);
            end
        end
    end

`ifdef MASTERMIND_PARTIAL_EN
    localparam int NSYM = 2 ** SYM_W;

    // Total symbol overlap is the sum over symbol values of the smaller of the
    // two occurrence counts. Exact hits are part of that overlap, so taking
    // them away leaves the wrong-position matches.
    logic [EW-1:0] w_overlap;

    always_comb begin
        logic [EW-1:0] v_cnt_g;
        logic [EW-1:0] v_cnt_s;
        w_overlap = '0;
        for (int v = 0; v < NSYM; v++) begin
            v_cnt_g = '0;
            v_cnt_s = '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (hMove[i*SYM_W +: SYM_W] == SYM_W'(v)) begin
                    v_cnt_g = v_cnt_g + EW'(1);
                end
                if (r_secret[i*SYM_W +: SYM_W] == SYM_W'(v)) begin
                    v_cnt_s = v_cnt_s + EW'(1);
                end
            end
            w_overlap = w_overlap + ((v_cnt_g < v_cnt_s) ? v_cnt_g : v_cnt_s);
        end
        w_partial = w_overlap - w_exact;
    end
`else
    assign w_partial = '0;
`endif

    assign w_full_match = (w_exact == EW'(NUM_SLOTS));

    // The round count never wraps, even if scoring were to continue.
    assign w_round_inc = (r_round >= RW'(MAX_ROUNDS)) ? r_round : (r_round + RW'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!new_game_L) begin
            w_state_next = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_press) begin
                        w_state_next = S_GUESS;
                    end
                end
                S_GUESS: begin
                    if (w_press) begin
                        // A winning guess in the last round still wins.
                        if (w_full_match) begin
                            w_state_next = S_WON;
                        end else if (w_round_inc == RW'(MAX_ROUNDS)) begin
                            w_state_next = S_LOST;
                        end
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_enter_q <= 1'b1;
            r_secret  <= '0;
            r_last    <= '0;
            r_exact   <= '0;
            r_partial <= '0;
            r_round   <= '0;
        end else begin
            r_enter_q <= enter_L;
            if (!new_game_L) begin
                r_secret  <= '0;
                r_last    <= '0;
                r_exact   <= '0;
                r_partial <= '0;
                r_round   <= '0;
            end else if (w_press) begin
                if (r_state == S_LOAD) begin
                    r_secret <= hMove;
                end else if (r_state == S_GUESS) begin
                    r_last    <= hMove;
                    r_exact   <= w_exact;
                    r_partial <= w_partial;
                    r_round   <= w_round_inc;
                end
            end
        end
    end

    assign loading    = (r_state == S_LOAD);
    assign win        = (r_state == S_WON);
    assign lose       = (r_state == S_LOST);
    assign exact      = r_exact;
    assign partial    = r_partial;
    assign round      = r_round;
    assign hMove_last = r_last;

endmodule

// File: doc/mastermind_core.md
MASTERMIND_CORE -- requirements
Module: mastermind_core

Interface
REQ-001 Parameter NUM_SLOTS, default 4: number of symbol positions per code word.
REQ-002 Parameter SYM_W, default 4: bits per symbol; 2**SYM_W legal symbol values.
REQ-003 Parameter MAX_ROUNDS, default 8: guesses allowed per game.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enter_L  input  1  active-low enter button, already synchronised to clock.
REQ-007 new_game_L  input  1  active-low new-game request, level-sensitive, synchronous.
REQ-008 hMove  input  NUM_SLOTS*SYM_W  code word; slot 0 = bits [SYM_W-1:0].
REQ-009 loading  output  1  high while waiting for the secret word.
REQ-010 exact  output  $clog2(NUM_SLOTS+1)  count of slots with symbol and position both correct.
REQ-011 partial  output  $clog2(NUM_SLOTS+1)  count of correct symbols in wrong position.
REQ-012 round  output  $clog2(MAX_ROUNDS+1)  number of guesses scored this game.
REQ-013 hMove_last  output  NUM_SLOTS*SYM_W  last scored guess.
REQ-014 win / lose  output  1 each  game outcome flags, mutually exclusive.

Function
REQ-015 FSM states: LOAD, GUESS, WON, LOST.
REQ-016 Press = enter_L sampled 1 on previous edge and 0 on current edge; held-low enter_L yields exactly one press.
REQ-017 LOAD: on a press, capture hMove as secret, go to GUESS; round, exact, partial remain 0.
REQ-018 GUESS: on a press, score hMove against secret; exact, partial, hMove_last and round (+1) update on the edge that detects the press (one-clock latency from sampled falling edge).
REQ-019 exact = number of slots i with guess[i]==secret[i].
REQ-020 partial = sum over symbol values v of min(count_v(guess), count_v(secret)) minus exact; never exceeds NUM_SLOTS-exact.
REQ-021 GUESS -> WON when scored exact==NUM_SLOTS; win=1.
REQ-022 GUESS -> LOST when scored guess makes round==MAX_ROUNDS and exact<NUM_SLOTS; lose=1.
REQ-023 Winning guess on round MAX_ROUNDS: WON takes precedence; lose stays 0.
REQ-024 WON/LOST: presses ignored; all outputs hold.
REQ-025 new_game_L low in any state: next state LOAD, exact/partial/round/win/lose cleared, hMove_last cleared, secret cleared; overrides a simultaneous press.
REQ-026 round saturates at MAX_ROUNDS; never wraps.
REQ-027 loading = 1 exactly in LOAD.
REQ-028 All symbol values 0..2**SYM_W-1 legal in secret and guess; repeated symbols allowed.

Reset
REQ-029 reset high: state LOAD, secret 0, enter edge detector history 1, all outputs 0 except loading=1; takes effect immediately, independent of clock.
REQ-030 reset asserted mid-game discards secret and score; first press after release loads a new secret.

Configuration
REQ-031 Macro MASTERMIND_PARTIAL_EN: defined -> partial computed per REQ-020.
REQ-032 Macro MASTERMIND_PARTIAL_EN undefined -> partial tied to 0, symbol-count logic absent; all other behaviour unchanged.

Verification
REQ-033 Defaults; secret 16'h1234, guess 16'h1234 -> next edge exact=4, partial=0, round=1, win=1.
REQ-034 Secret 16'h1123, guess 16'h3211 -> exact=0, partial=4 (0 with macro undefined); guess 16'h1111 -> exact=2, partial=0.
REQ-035 Secret 16'h0000, eight guesses 16'hFFFF -> round=8, lose=1 after eighth; ninth press -> round stays 8.
REQ-036 Seven misses then 16'h0000 on round 8 -> win=1, lose=0.
REQ-037 enter_L held low 10 cycles in GUESS -> round increments once; press with new_game_L low -> LOAD, round=0.
REQ-038 reset pulsed mid-game (round=3) between edges -> outputs 0 and loading=1 immediately; NUM_SLOTS=6, SYM_W=3 instance repeats REQ-033 with 18-bit word.
